// File: rtl/rv32_pipe_pkg.sv
// Shared types and widths for the rv32im pipeline stage registers.
// Holds the default datapath widths, the write-back payload layout and a slot-count helper.
package rv32_pipe_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef struct packed {
      logic [XLEN-1:0]      result;
      logic [REG_IDX_W-1:0] rd;
      logic                 useRd;
   } wb_payload_t;

   // Occupancy of a two-slot stage from its valid bits.
   function automatic logic [1:0] slot_count(input logic m_valid, input logic s_valid);
      return {1'b0, m_valid} + {1'b0, s_valid};
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register with load and clear.
// Clear wins over load so a flush can never be undone by a same-cycle capture.
module pipe_slot #(
   parameter int PW = 38
) (
   input  logic          clk,
   input  logic          a_reset,
   input  logic          load,
   input  logic          clear,
   input  logic [PW-1:0] d,
   output logic          valid,
   output logic [PW-1:0] q
);

   logic          valid_reg;
   logic [PW-1:0] data_reg;

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else begin
         if (clear) begin
            valid_reg <= 1'b0;
         end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d;
         end
      end
   end

   assign valid = valid_reg;
   assign q     = data_reg;

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB stage register with valid/ready handshake, optional skid entry,
// synchronous flush and suppression of register-file writes to x0.
module wb_stage_reg
   import rv32_pipe_pkg::*;
#(
   parameter int W    = XLEN,
   parameter int R    = REG_IDX_W,
   parameter bit SKID = 1'b1
) (
   input  logic         clk,
   input  logic         a_reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_result,
   input  logic [R-1:0] in_rd,
   input  logic         in_useRd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic [R-1:0] out_rd,
   output logic         out_useRd,
   output logic         out_rdWrite,
   output logic [1:0]   out_count
);

   localparam int PW = W + R + 1;

   logic [PW-1:0] in_payload;
   logic [PW-1:0] m_payload;
   logic [PW-1:0] s_payload;
   logic [PW-1:0] m_next;
   logic          m_valid;
   logic          s_valid;
   logic          m_load;
   logic          m_clear;
   logic          s_load;
   logic          s_clear;
   logic          m_from_s;
   logic          accept;
   logic          pop;

   assign in_payload = {in_result, in_rd, in_useRd};
   assign accept     = in_valid & in_ready & ~flush;
   assign pop        = m_valid & out_ready;

   always_comb begin
      m_load   = 1'b0;
      m_clear  = 1'b0;
      s_load   = 1'b0;
      s_clear  = 1'b0;
      m_from_s = 1'b0;
      if (flush) begin
         m_clear = 1'b1;
         s_clear = 1'b1;
      end else if (!m_valid) begin
         m_load = accept;
      end else if (pop) begin
         if (s_valid) begin
            // Skid entry is older than anything upstream; in_ready is low here.
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
         end else if (accept) begin
            m_load = 1'b1;
         end else begin
            m_clear = 1'b1;
         end
      end else if (accept) begin
         s_load = 1'b1;
      end
   end

   assign m_next = m_from_s ? s_payload : in_payload;

   pipe_slot #(.PW(PW)) u_m_slot (
      .clk     (clk),
      .a_reset (a_reset),
      .load    (m_load),
      .clear   (m_clear),
      .d       (m_next),
      .valid   (m_valid),
      .q       (m_payload)
   );

   generate
      if (SKID) begin : g_skid
         // Registered ready: no combinational path from out_ready to in_ready.
         pipe_slot #(.PW(PW)) u_s_slot (
            .clk     (clk),
            .a_reset (a_reset),
            .load    (s_load),
            .clear   (s_clear),
            .d       (in_payload),
            .valid   (s_valid),
            .q       (s_payload)
         );
         assign in_ready = ~s_valid;
      end else begin : g_noskid
         assign s_valid  = 1'b0;
         assign s_payload = '0;
         assign in_ready = ~m_valid | out_ready;
      end
   endgenerate

   assign out_valid   = m_valid;
   assign {out_result, out_rd, out_useRd} = m_payload;
   assign out_rdWrite = m_valid & out_useRd & (out_rd != '0);
   assign out_count   = slot_count(m_valid, s_valid);

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised successor to the plain MEM→WB pipeline register: a one-stage pipeline register for the result/rd/useRd payload with a valid/ready handshake, an optional second (skid) entry for full throughput under backpressure, a synchronous flush, and x0 write suppression. It sits between the memory stage and the register-file write port. It is reusable for any stage boundary of the rv32im pipeline whose downstream can stall.

## Interface
- W, 32: result width in bits.
- R, 5: destination register index width.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

- clk  in  1  rising-edge clock.
- a_reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  W  result value.
- in_rd  in  R  destination register index.
- in_useRd  in  1  instruction writes rd.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_result  out  W  head result.
- out_rd  out  R  head rd.
- out_useRd  out  1  head useRd, passed verbatim.
- out_rdWrite  out  1  out_valid & out_useRd & (out_rd != 0).
- out_count  out  2  entries held: 0, 1 or 2.

## Operation
- Two slots: M (head, drives out_*) and S (skid, SKID=1 only), each payload plus valid bit.
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- SKID=1: in_ready = !S.valid (register-derived, no path from out_ready).
- SKID=0: in_ready = !M.valid | out_ready. S is absent; out_count never exceeds 1.
- Slot update, flush clear:
  - M empty, accept: M ← input.
  - M full, pop, S full: M ← S; S cleared. Accept is impossible because in_ready = 0.
  - M full, pop, S empty: accept gives M ← input; no accept clears M.
  - M full, no pop, accept: S ← input. SKID=1 only, S necessarily empty.
  - M full, no pop, no accept: hold.
- flush: M.valid and S.valid cleared at the next edge. Overrides accept and pop. The downstream may still sample the head in the flush cycle. Payload contents after flush are don't-care but must not assert out_rdWrite.
- Ordering: strict FIFO. No payload is duplicated or dropped except by flush.
- out_rdWrite is low whenever out_rd = 0, regardless of out_useRd.

## Timing
- Reset (a_reset high, asynchronous):
  - out_valid, out_result, out_rd, out_useRd, out_rdWrite and out_count = 0.
  - S cleared.
  - in_ready = 1 for both SKID settings.
- Reset released mid-transfer: all held entries are lost. The first accept after release appears on out_* one cycle later.
- Latency: accept at edge n → out_valid high after edge n.
- Throughput: one payload per cycle when out_ready is held high.
- SKID=1 under backpressure: after out_ready falls, at most one further payload is accepted. in_ready falls the cycle after S fills and rises the cycle after S drains.
- Simultaneous accept and pop with M full, S empty: M is replaced and out_valid stays high with no bubble.
- out_count changes only on clock edges and reflects slot valid bits after the edge.

## Structure
- Shared package rv32_pipe_pkg holds:
  - XLEN = 32 and REG_IDX_W = 5, the defaults for W and R.
  - wb_payload_t: a packed struct of result, rd and useRd.
- One sub-module, pipe_slot: a valid bit plus payload register with load/clear, instantiated as M and, under generate for SKID=1, as S.
- out_rdWrite and out_count are combinational from the slot valid bits and the M payload.

## Test plan
- Reset then stream: assert a_reset, release, then send in_valid for 4 cycles with result 0x11..0x44, rd 1..4, out_ready = 1. Required: out_valid from cycle 1 and results 0x11..0x44 in consecutive cycles. out_count stays at 1 during the stream and drops to 0 after the last pop.
- Backpressure, SKID=1: stream 0xA0..0xA3 with out_ready low for cycles 2–4.
  - 0xA0 held, 0xA1 captured in S, in_ready low.
  - Order 0xA0..0xA3 preserved on release.
  - out_count = 2 while stalled.
- Backpressure, SKID=0: same stimulus. Required: in_ready follows out_ready the same cycle, out_count ≤ 1, no loss.
- Flush with both slots full: flush coincides with in_valid = 1 and out_ready = 1.
  - Next cycle out_valid = 0 and out_count = 0.
  - The concurrent input is not captured.
  - in_ready = 1.
- x0 suppression: send rd = 0, useRd = 1, result 0xDEADBEEF. Required: out_useRd = 1 and out_rdWrite = 0. The same payload with rd = 5 gives out_rdWrite = 1.
- Async reset mid-stall: pulse a_reset between edges with 2 entries held. Required: outputs go to 0 immediately without waiting for a clock edge, and in_ready = 1.
